// File: rtl/ysyx_22041461_lsu_pkg.sv
// Shared definitions for the load/store stage: op codes, FSM states, fault
// codes and small op-decoding helpers used by the top and the lane aligner.
package ysyx_22041461_lsu_pkg;

    localparam logic [3:0] MEM_NOP = 4'd0;
    localparam logic [3:0] MEM_LB  = 4'd1;
    localparam logic [3:0] MEM_LH  = 4'd2;
    localparam logic [3:0] MEM_LW  = 4'd3;
    localparam logic [3:0] MEM_LD  = 4'd4;
    localparam logic [3:0] MEM_LBU = 4'd5;
    localparam logic [3:0] MEM_LHU = 4'd6;
    localparam logic [3:0] MEM_LWU = 4'd7;
    localparam logic [3:0] MEM_SB  = 4'd8;
    localparam logic [3:0] MEM_SH  = 4'd9;
    localparam logic [3:0] MEM_SW  = 4'd10;
    localparam logic [3:0] MEM_SD  = 4'd11;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_WAIT = 2'd2,
        LSU_OUT  = 2'd3
    } lsu_state_e;

    typedef enum logic [1:0] {
        LSU_NO_FAULT       = 2'd0,
        LSU_FAULT_MISALIGN = 2'd1,
        LSU_FAULT_BUSERR   = 2'd2
    } lsu_fault_e;

    function automatic logic op_is_load(input logic [3:0] op);
        return (op == MEM_LB)  || (op == MEM_LH)  || (op == MEM_LW) ||
               (op == MEM_LD)  || (op == MEM_LBU) || (op == MEM_LHU) ||
               (op == MEM_LWU);
    endfunction

    function automatic logic op_is_store(input logic [3:0] op);
        return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW) || (op == MEM_SD);
    endfunction

    // log2 of the access size in bytes; unknown ops report byte size
    function automatic logic [1:0] op_size(input logic [3:0] op);
        logic [1:0] sz;
        case (op)
            MEM_LH, MEM_LHU, MEM_SH: sz = 2'd1;
            MEM_LW, MEM_LWU, MEM_SW: sz = 2'd2;
            MEM_LD, MEM_SD:          sz = 2'd3;
            default:                 sz = 2'd0;
        endcase
        return sz;
    endfunction

endpackage

// File: rtl/ysyx_22041461_lsu_align.sv
// Combinational byte-lane logic: store data/strobe placement, misalignment
// detection for the op being accepted, and load lane select plus extension.
module ysyx_22041461_lsu_align
    import ysyx_22041461_lsu_pkg::*;
(
    input  logic [3:0]  acc_op_i,
    input  logic [2:0]  acc_off_i,
    input  logic [63:0] acc_data_i,
    output logic [63:0] st_wdata_o,
    output logic [7:0]  st_wmask_o,
    output logic        misalign_o,
    input  logic [3:0]  ld_op_i,
    input  logic [2:0]  ld_off_i,
    input  logic [63:0] ld_rdata_i,
    output logic [63:0] ld_data_o
);

    logic [1:0]  acc_size;
    logic [7:0]  base_mask;
    logic [63:0] lane;

    assign acc_size = op_size(acc_op_i);

    // strobe pattern for the access size before shifting into place
    always_comb begin
        case (acc_size)
            2'd0:    base_mask = 8'h01;
            2'd1:    base_mask = 8'h03;
            2'd2:    base_mask = 8'h0F;
            default: base_mask = 8'hFF;
        endcase
    end

    assign st_wmask_o = base_mask << acc_off_i;
    assign st_wdata_o = acc_data_i << {acc_off_i, 3'b000};

    // natural alignment check on the low address bits
    always_comb begin
        case (acc_size)
            2'd0:    misalign_o = 1'b0;
            2'd1:    misalign_o = acc_off_i[0];
            2'd2:    misalign_o = |acc_off_i[1:0];
            default: misalign_o = |acc_off_i;
        endcase
    end

    assign lane = ld_rdata_i >> {ld_off_i, 3'b000};

    // sign or zero extension of the selected lane
    always_comb begin
        case (ld_op_i)
            MEM_LB:  ld_data_o = {{56{lane[7]}},  lane[7:0]};
            MEM_LH:  ld_data_o = {{48{lane[15]}}, lane[15:0]};
            MEM_LW:  ld_data_o = {{32{lane[31]}}, lane[31:0]};
            MEM_LBU: ld_data_o = {56'd0, lane[7:0]};
            MEM_LHU: ld_data_o = {48'd0, lane[15:0]};
            MEM_LWU: ld_data_o = {32'd0, lane[31:0]};
            default: ld_data_o = lane;
        endcase
    end

endmodule

// File: rtl/ysyx_22041461_lsu.sv
// Load/store stage: one outstanding aligned 64-bit bus transaction, registered
// result handed to write-back over valid/ready.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | output register empty, ready to accept from execute
// REQ      | mem_req asserted with stable command until mem_gnt
// WAIT     | load granted, waiting for mem_rvalid
// OUT      | output register full, MEM_valid_out held until MEM_ready_in
module ysyx_22041461_lsu
    import ysyx_22041461_lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MEM_valid_in,
    output logic        MEM_ready_out,
    input  logic [63:0] MEM_exe_out,
    input  logic [63:0] MEM_rs2_data,
    input  logic [3:0]  MEM_op,
    input  logic [4:0]  MEM_rd_in,
    output logic        mem_req,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic [7:0]  mem_wmask,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [63:0] mem_rdata,
    output logic        MEM_valid_out,
    input  logic        MEM_ready_in,
    output logic [63:0] MEM_out,
    output logic [4:0]  MEM_rd_out,
    output logic        MEM_misalign,
    output logic        MEM_buserr
);

    localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYCLES);

    lsu_state_e  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [63:0] addr_q, addr_d;
    logic [2:0]  off_q, off_d;
    logic [3:0]  op_q, op_d;
    logic        we_q, we_d;
    logic [63:0] wdata_q, wdata_d;
    logic [7:0]  wmask_q, wmask_d;
    logic [4:0]  rd_pend_q, rd_pend_d;
    logic [63:0] out_q, out_d;
    logic [4:0]  rd_out_q, rd_out_d;
    lsu_fault_e  fault_q, fault_d;

    logic        accept;
    logic        is_mem;
    logic        misalign;
    logic [7:0]  tick;
    logic        timeout;
    logic [63:0] st_wdata;
    logic [7:0]  st_wmask;
    logic [63:0] ld_data;

    ysyx_22041461_lsu_align u_align (
        .acc_op_i   (MEM_op),
        .acc_off_i  (MEM_exe_out[2:0]),
        .acc_data_i (MEM_rs2_data),
        .st_wdata_o (st_wdata),
        .st_wmask_o (st_wmask),
        .misalign_o (misalign),
        .ld_op_i    (op_q),
        .ld_off_i   (off_q),
        .ld_rdata_i (mem_rdata),
        .ld_data_o  (ld_data)
    );

    // in OUT a new op is taken only in the same cycle the current result leaves
    assign MEM_ready_out = (state_q == LSU_IDLE) || ((state_q == LSU_OUT) && MEM_ready_in);
    assign accept        = MEM_valid_in && MEM_ready_out;
    assign is_mem        = op_is_load(MEM_op) || op_is_store(MEM_op);

    // the count includes the current REQ/WAIT cycle
    assign tick    = cnt_q + 8'd1;
    assign timeout = (tick == TO_LIMIT);

    // next-state, transaction capture and output-register update
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        off_d     = off_q;
        op_d      = op_q;
        we_d      = we_q;
        wdata_d   = wdata_q;
        wmask_d   = wmask_q;
        rd_pend_d = rd_pend_q;
        out_d     = out_q;
        rd_out_d  = rd_out_q;
        fault_d   = fault_q;

        case (state_q)
            LSU_REQ: begin
                cnt_d = tick;
                if (mem_gnt) begin
                    if (we_q) begin
                        out_d    = '0;
                        fault_d  = LSU_NO_FAULT;
                        rd_out_d = rd_pend_q;
                        state_d  = LSU_OUT;
                    end else begin
                        state_d = LSU_WAIT;
                    end
                end else if (timeout) begin
                    out_d    = '0;
                    fault_d  = LSU_FAULT_BUSERR;
                    rd_out_d = rd_pend_q;
                    state_d  = LSU_OUT;
                end
            end
            LSU_WAIT: begin
                cnt_d = tick;
                if (mem_rvalid) begin
                    out_d    = ld_data;
                    fault_d  = LSU_NO_FAULT;
                    rd_out_d = rd_pend_q;
                    state_d  = LSU_OUT;
                end else if (timeout) begin
                    out_d    = '0;
                    fault_d  = LSU_FAULT_BUSERR;
                    rd_out_d = rd_pend_q;
                    state_d  = LSU_OUT;
                end
            end
            LSU_OUT: begin
                if (MEM_ready_in) begin
                    state_d = LSU_IDLE;
                end
            end
            default: begin
            end
        endcase

        // accepting overrides the OUT->IDLE drain decided above
        if (accept) begin
            if (!is_mem) begin
                out_d    = MEM_exe_out;
                fault_d  = LSU_NO_FAULT;
                rd_out_d = MEM_rd_in;
                state_d  = LSU_OUT;
            end else if (misalign) begin
                out_d    = '0;
                fault_d  = LSU_FAULT_MISALIGN;
                rd_out_d = MEM_rd_in;
                state_d  = LSU_OUT;
            end else begin
                addr_d    = {MEM_exe_out[63:3], 3'b000};
                off_d     = MEM_exe_out[2:0];
                op_d      = MEM_op;
                we_d      = op_is_store(MEM_op);
                wdata_d   = st_wdata;
                wmask_d   = st_wmask;
                rd_pend_d = MEM_rd_in;
                cnt_d     = '0;
                state_d   = LSU_REQ;
            end
        end
    end

    // state and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= LSU_IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            off_q     <= '0;
            op_q      <= MEM_NOP;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            wmask_q   <= '0;
            rd_pend_q <= '0;
            out_q     <= '0;
            rd_out_q  <= '0;
            fault_q   <= LSU_NO_FAULT;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            off_q     <= off_d;
            op_q      <= op_d;
            we_q      <= we_d;
            wdata_q   <= wdata_d;
            wmask_q   <= wmask_d;
            rd_pend_q <= rd_pend_d;
            out_q     <= out_d;
            rd_out_q  <= rd_out_d;
            fault_q   <= fault_d;
        end
    end

    // bus command is only driven while requesting, zero otherwise
    assign mem_req   = (state_q == LSU_REQ);
    assign mem_we    = mem_req && we_q;
    assign mem_addr  = mem_req ? addr_q  : '0;
    assign mem_wdata = mem_req ? wdata_q : '0;
    assign mem_wmask = mem_req ? wmask_q : '0;

    assign MEM_valid_out = (state_q == LSU_OUT);
    assign MEM_out       = out_q;
    assign MEM_rd_out    = rd_out_q;
    assign MEM_misalign  = (fault_q == LSU_FAULT_MISALIGN);
    assign MEM_buserr    = (fault_q == LSU_FAULT_BUSERR);

endmodule

// File: tb/tb_ysyx_22041461_lsu.sv
// Directed and randomized checks of the load/store stage against a byte-level
// reference model of the access rules.
module tb_ysyx_22041461_lsu;
    import ysyx_22041461_lsu_pkg::*;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        MEM_valid_in;
    logic        MEM_ready_out;
    logic [63:0] MEM_exe_out;
    logic [63:0] MEM_rs2_data;
    logic [3:0]  MEM_op;
    logic [4:0]  MEM_rd_in;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [63:0] mem_rdata;
    logic        MEM_valid_out;
    logic        MEM_ready_in;
    logic [63:0] MEM_out;
    logic [4:0]  MEM_rd_out;
    logic        MEM_misalign;
    logic        MEM_buserr;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ysyx_22041461_lsu #(.TIMEOUT_CYCLES(TO)) dut (
        .clk           (clk),
        .rst           (rst),
        .MEM_valid_in  (MEM_valid_in),
        .MEM_ready_out (MEM_ready_out),
        .MEM_exe_out   (MEM_exe_out),
        .MEM_rs2_data  (MEM_rs2_data),
        .MEM_op        (MEM_op),
        .MEM_rd_in     (MEM_rd_in),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_wmask     (mem_wmask),
        .mem_gnt       (mem_gnt),
        .mem_rvalid    (mem_rvalid),
        .mem_rdata     (mem_rdata),
        .MEM_valid_out (MEM_valid_out),
        .MEM_ready_in  (MEM_ready_in),
        .MEM_out       (MEM_out),
        .MEM_rd_out    (MEM_rd_out),
        .MEM_misalign  (MEM_misalign),
        .MEM_buserr    (MEM_buserr)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // access size in bytes, 0 for pass-through
    function automatic int ref_size(input logic [3:0] op);
        case (op)
            MEM_LB, MEM_LBU, MEM_SB: return 1;
            MEM_LH, MEM_LHU, MEM_SH: return 2;
            MEM_LW, MEM_LWU, MEM_SW: return 4;
            MEM_LD, MEM_SD:          return 8;
            default:                 return 0;
        endcase
    endfunction

    function automatic bit ref_store(input logic [3:0] op);
        return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW) || (op == MEM_SD);
    endfunction

    function automatic bit ref_signed(input logic [3:0] op);
        return (op == MEM_LB) || (op == MEM_LH) || (op == MEM_LW);
    endfunction

    // gather n bytes starting at byte off, then extend arithmetically
    function automatic logic [63:0] ref_load(input logic [3:0] op, input int off, input logic [63:0] rdata);
        int n;
        logic [63:0] v;
        n = ref_size(op);
        v = '0;
        for (int i = 0; i < n; i++)
            v = v | (((rdata >> (8 * (off + i))) & 64'hFF) << (8 * i));
        if (ref_signed(op) && v[8 * n - 1])
            v = v - (64'd1 << (8 * n));
        return v;
    endfunction

    function automatic logic [7:0] ref_mask(input int n, input int off);
        logic [15:0] m;
        m = (16'd1 << n) - 16'd1;
        m = m << off;
        return m[7:0];
    endfunction

    // gnt_at/rv_at: cycle within REQ/WAIT where the response arrives, 0 = never
    task automatic run_op(input string nm, input logic [3:0] op, input logic [63:0] exe,
                          input logic [63:0] rs2, input logic [4:0] rd, input int gnt_at,
                          input int rv_at, input logic [63:0] rdata, input int stall);
        int n, off, k, reqc, waitc;
        bit st, mis, in_req, done, exp_mis, exp_be;
        logic [63:0] exp_out;
        n = ref_size(op);
        off = int'(exe[2:0]);
        st = ref_store(op);
        mis = (n > 0) && ((off % n) != 0);
        exp_mis = 1'b0;
        exp_be = 1'b0;
        exp_out = '0;
        chk({nm, ".rdy_idle"}, 64'(MEM_ready_out), 64'd1);
        MEM_valid_in = 1'b1;
        MEM_op = op;
        MEM_exe_out = exe;
        MEM_rs2_data = rs2;
        MEM_rd_in = rd;
        MEM_ready_in = 1'b0;
        step();
        MEM_valid_in = 1'b0;
        MEM_exe_out = {$urandom, $urandom};
        MEM_rs2_data = {$urandom, $urandom};
        if (n == 0) begin
            exp_out = exe;
        end else if (mis) begin
            exp_mis = 1'b1;
        end else begin
            in_req = 1'b1;
            done = 1'b0;
            k = 0;
            reqc = 0;
            waitc = 0;
            while (!done) begin
                k++;
                if (in_req) begin
                    reqc++;
                    chk({nm, ".req"}, 64'(mem_req), 64'd1);
                    chk({nm, ".addr"}, mem_addr, exe & ~64'h7);
                    chk({nm, ".we"}, 64'(mem_we), 64'(st));
                    if (st) begin
                        chk({nm, ".wdata"}, mem_wdata, rs2 << (8 * off));
                        chk({nm, ".wmask"}, 64'(mem_wmask), 64'(ref_mask(n, off)));
                    end
                    if (reqc == gnt_at) mem_gnt = 1'b1;
                end else begin
                    waitc++;
                    chk({nm, ".req_wait"}, 64'(mem_req), 64'd0);
                    if (waitc == rv_at) begin
                        mem_rvalid = 1'b1;
                        mem_rdata = rdata;
                    end
                end
                chk({nm, ".rdy_busy"}, 64'(MEM_ready_out), 64'd0);
                if (in_req && reqc == gnt_at) begin
                    if (st) done = 1'b1;
                    else in_req = 1'b0;
                end else if (!in_req && waitc == rv_at) begin
                    done = 1'b1;
                    exp_out = ref_load(op, off, rdata);
                end else if (k == TO) begin
                    done = 1'b1;
                    exp_be = 1'b1;
                end
                step();
                mem_gnt = 1'b0;
                mem_rvalid = 1'b0;
                mem_rdata = {$urandom, $urandom};
            end
        end
        for (int s = 0; s <= stall; s++) begin
            chk({nm, ".valid"}, 64'(MEM_valid_out), 64'd1);
            chk({nm, ".out"}, MEM_out, exp_out);
            chk({nm, ".rd"}, 64'(MEM_rd_out), 64'(rd));
            chk({nm, ".misalign"}, 64'(MEM_misalign), 64'(exp_mis));
            chk({nm, ".buserr"}, 64'(MEM_buserr), 64'(exp_be));
            chk({nm, ".req_out"}, 64'(mem_req), 64'd0);
            chk({nm, ".rdy_out"}, 64'(MEM_ready_out), 64'd0);
            if (s == stall) begin
                MEM_ready_in = 1'b1;
            end else begin
                mem_rvalid = 1'b1;
                mem_rdata = {$urandom, $urandom};
            end
            step();
            mem_rvalid = 1'b0;
        end
        chk({nm, ".drained"}, 64'(MEM_valid_out), 64'd0);
        chk({nm, ".rdy_back"}, 64'(MEM_ready_out), 64'd1);
        MEM_ready_in = 1'b0;
    endtask

    initial begin
        logic [3:0]  r_op;
        logic [63:0] r_exe;
        int r_n, r_g, r_v;
        logic [63:0] v_prev;

        rst = 1'b1;
        MEM_valid_in = 1'b0;
        MEM_exe_out = '0;
        MEM_rs2_data = '0;
        MEM_op = MEM_NOP;
        MEM_rd_in = '0;
        mem_gnt = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata = '0;
        MEM_ready_in = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk("rst.ready", 64'(MEM_ready_out), 64'd1);
        chk("rst.valid", 64'(MEM_valid_out), 64'd0);
        chk("rst.req", 64'(mem_req), 64'd0);
        chk("rst.we", 64'(mem_we), 64'd0);
        chk("rst.addr", mem_addr, 64'd0);
        chk("rst.wdata", mem_wdata, 64'd0);
        chk("rst.wmask", 64'(mem_wmask), 64'd0);
        chk("rst.out", MEM_out, 64'd0);
        chk("rst.rd", 64'(MEM_rd_out), 64'd0);
        chk("rst.misalign", 64'(MEM_misalign), 64'd0);
        chk("rst.buserr", 64'(MEM_buserr), 64'd0);

        run_op("nop", MEM_NOP, 64'h1234, 64'd0, 5'd7, 0, 0, 64'd0, 0);
        run_op("lb", MEM_LB, 64'h8000_0003, 64'd0, 5'd1, 1, 1, 64'h0000_0000_8000_0000, 0);
        run_op("lbu", MEM_LBU, 64'h8000_0003, 64'd0, 5'd2, 1, 1, 64'h0000_0000_8000_0000, 0);
        run_op("sh", MEM_SH, 64'h8000_0006, 64'hABCD, 5'd3, 3, 0, 64'd0, 0);
        run_op("lw_mis", MEM_LW, 64'h8000_0002, 64'd0, 5'd4, 1, 1, 64'd0, 0);
        run_op("ld_to", MEM_LD, 64'h8000_0008, 64'd0, 5'd5, 0, 0, 64'd0, 0);
        run_op("ld_g4", MEM_LD, 64'h8000_0008, 64'd0, 5'd6, 4, 1, 64'h0123_4567_89AB_CDEF, 0);
        run_op("lw_rv4", MEM_LW, 64'h8000_0004, 64'd0, 5'd8, 1, 3, 64'hF234_5678_0000_0000, 0);
        run_op("lw_wto", MEM_LWU, 64'h8000_0004, 64'd0, 5'd9, 2, 0, 64'd0, 0);
        run_op("ld_stall", MEM_LD, 64'h8000_0010, 64'd0, 5'd10, 2, 2, 64'hDEAD_BEEF_CAFE_F00D, 5);

        // back-to-back NOPs, then a store accepted straight out of OUT
        MEM_ready_in = 1'b1;
        MEM_valid_in = 1'b1;
        MEM_op = MEM_NOP;
        MEM_rd_in = 5'd11;
        v_prev = {$urandom, $urandom};
        MEM_exe_out = v_prev;
        step();
        for (int i = 0; i < 4; i++) begin
            chk("b2b.valid", 64'(MEM_valid_out), 64'd1);
            chk("b2b.out", MEM_out, v_prev);
            chk("b2b.ready", 64'(MEM_ready_out), 64'd1);
            v_prev = {$urandom, $urandom};
            MEM_exe_out = v_prev;
            step();
        end
        MEM_op = MEM_SD;
        MEM_exe_out = 64'h100;
        MEM_rs2_data = 64'h5555_AAAA_1234_8765;
        step();
        MEM_valid_in = 1'b0;
        MEM_ready_in = 1'b0;
        chk("b2b_sd.valid", 64'(MEM_valid_out), 64'd0);
        chk("b2b_sd.req", 64'(mem_req), 64'd1);
        chk("b2b_sd.addr", mem_addr, 64'h100);
        chk("b2b_sd.wmask", 64'(mem_wmask), 64'hFF);
        chk("b2b_sd.wdata", mem_wdata, 64'h5555_AAAA_1234_8765);
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        chk("b2b_sd.done", 64'(MEM_valid_out), 64'd1);
        chk("b2b_sd.out", MEM_out, 64'd0);
        MEM_ready_in = 1'b1;
        step();
        MEM_ready_in = 1'b0;
        chk("b2b_sd.idle", 64'(MEM_valid_out), 64'd0);

        // reset while waiting for load data, then a stale rvalid
        MEM_valid_in = 1'b1;
        MEM_op = MEM_LD;
        MEM_exe_out = 64'h8000_0020;
        MEM_rd_in = 5'd12;
        step();
        MEM_valid_in = 1'b0;
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        chk("rstw.in_wait", 64'(mem_req), 64'd0);
        chk("rstw.busy", 64'(MEM_ready_out), 64'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rstw.req", 64'(mem_req), 64'd0);
        chk("rstw.valid", 64'(MEM_valid_out), 64'd0);
        chk("rstw.ready", 64'(MEM_ready_out), 64'd1);
        chk("rstw.out", MEM_out, 64'd0);
        chk("rstw.rd", 64'(MEM_rd_out), 64'd0);
        mem_rvalid = 1'b1;
        mem_rdata = 64'hFFFF_0000_FFFF_0000;
        step();
        mem_rvalid = 1'b0;
        chk("rstw.late_valid", 64'(MEM_valid_out), 64'd0);
        chk("rstw.late_out", MEM_out, 64'd0);

        for (int it = 0; it < 40; it++) begin
            r_op = 4'($urandom_range(0, 11));
            r_exe = {$urandom, $urandom};
            r_n = ref_size(r_op);
            if (r_n > 0 && $urandom_range(0, 3) != 0)
                r_exe = r_exe - (r_exe % 64'(r_n));
            r_g = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 3));
            if (r_g == 0) r_v = 1;
            else r_v = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 4 - r_g));
            run_op("rnd", r_op, r_exe, {$urandom, $urandom}, 5'($urandom_range(0, 31)),
                   r_g, r_v, {$urandom, $urandom}, int'($urandom_range(0, 2)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ysyx_22041461_lsu.md
# ysyx_22041461_lsu

Load/store stage directly downstream of the execute unit. It takes the execute result, which is either an ALU result or an effective address, together with the store data and a memory op code. It performs at most one outstanding aligned 64-bit memory transaction over a req/gnt/rvalid bus, applies byte-lane selection and sign/zero extension, and hands a registered result to write-back over a valid/ready handshake.

## Interface
- `TIMEOUT_CYCLES`, 255, max cycles spent in REQ+WAIT before abort (1..255, 8-bit counter)
- `clk` in 1 — clock
- `rst` in 1 — synchronous, active-high reset
- `MEM_valid_in` in 1 — execute result valid
- `MEM_ready_out` out 1 — stage can accept
- `MEM_exe_out` in 64 — execute result / effective address
- `MEM_rs2_data` in 64 — store data
- `MEM_op` in 4 — memory op code, from the shared macro file
- `MEM_rd_in` in 5 — destination register, passed through
- `mem_req` out 1 — bus request
- `mem_we` out 1 — write enable
- `mem_addr` out 64 — address, bits [2:0] forced 0
- `mem_wdata` out 64 — lane-shifted store data
- `mem_wmask` out 8 — byte strobes
- `mem_gnt` in 1 — request accepted
- `mem_rvalid` in 1 — load data valid
- `mem_rdata` in 64 — load data (8-byte word)
- `MEM_valid_out` out 1 — result valid to write-back
- `MEM_ready_in` in 1 — write-back can accept
- `MEM_out` out 64 — result
- `MEM_rd_out` out 5 — destination register
- `MEM_misalign` out 1 — result is a misaligned-access fault
- `MEM_buserr` out 1 — result is a timeout fault

## Operation
- Op codes: `MEM_NOP` (pass-through), `LB`, `LH`, `LW`, `LD`, `LBU`, `LHU`, `LWU`, `SB`, `SH`, `SW`, `SD`.
- FSM states are IDLE, REQ, WAIT and OUT. OUT means the output register is full.
- **IDLE:** `MEM_ready_out` = 1. On handshake:
  - NOP → latch `MEM_exe_out` into the output register, go to OUT.
  - Misaligned access → no bus activity; latch `MEM_out`=0 and `MEM_misalign`=1, go to OUT.
    - Halfword misaligned: addr[0]≠0. Word: addr[1:0]≠0. Doubleword: addr[2:0]≠0.
  - Aligned load/store → latch address, data and op; go to REQ.
- **REQ:** `mem_req`=1, with `mem_we`/`mem_addr`/`mem_wdata`/`mem_wmask` stable until `mem_gnt`.
  - On gnt, a store goes to OUT with `MEM_out`=0.
  - On gnt, a load goes to WAIT.
- **WAIT:** on `mem_rvalid`, select the lane `rdata >> (8*addr[2:0])`, extend by op (signed for LB/LH/LW, zero for LBU/LHU/LWU, none for LD), latch, go to OUT.
- **OUT:** `MEM_valid_out`=1 and outputs are held stable. On `MEM_ready_in`, go to IDLE.
  - If `MEM_ready_in` and `MEM_valid_in` are both high in this cycle, a NOP or misaligned op is accepted directly and stays in OUT; `MEM_ready_out` = `MEM_ready_in` in OUT.
  - A memory op is also accepted in that cycle and goes to REQ.
- **Store lanes:** `mem_wdata` = rs2 << (8*addr[2:0]). `mem_wmask` is 0x01/0x03/0x0F/0xFF shifted by addr[2:0].
- **Timeout:** counter cleared on entry to REQ, incremented each REQ/WAIT cycle.
  - When it equals `TIMEOUT_CYCLES` with no gnt/rvalid that cycle: drop `mem_req`, latch `MEM_out`=0 and `MEM_buserr`=1, go to OUT.
  - gnt or rvalid arriving in the same cycle as the timeout wins; no fault.
  - A late rvalid in IDLE or OUT is ignored.
- `MEM_rd_out` is passed through unchanged for every op, including faults.

## Timing
- Reset: state IDLE; all outputs 0 except `MEM_ready_out`=1; counter 0.
- Reset during REQ/WAIT abandons the transaction: `mem_req`=0 from the cycle after the reset edge.
- Latency, from the accept edge:
  - NOP/misaligned: `MEM_valid_out` in the next cycle.
  - Store: `mem_req` in the next cycle; valid the cycle after gnt.
  - Load: valid the cycle after rvalid.
- Single outstanding transaction. `MEM_ready_out`=0 in REQ and WAIT.
- The valid/ready rule is standard: a transfer occurs when both are high at a clock edge. Once valid is asserted it is not dropped before the transfer, and outputs do not change.
- Zero-wait bus (gnt in the first REQ cycle, rvalid in the following cycle): load accepted at edge N appears valid at N+3.

## Structure
- The shared macro file holds:
  - the `MEM_*` op encodings (4-bit);
  - FSM state encodings;
  - the `LSU_NO_FAULT` and fault constants.
- One sub-module, `ysyx_22041461_lsu_align`:
  - purely combinational;
  - store lane shift and mask;
  - load lane select and extension;
  - misalignment check.
- The FSM, counter and output register live in the top module.

## Test plan
- NOP, `MEM_exe_out`=0x1234, `MEM_ready_in`=1 → one cycle later `MEM_out`=0x1234, no `mem_req`; back-to-back NOPs sustain one per cycle.
- LB at addr 0x8000_0003; rdata=0x0000_0000_8000_0000 with gnt at cycle 1 and rvalid at cycle 2 → `MEM_out`=0xFFFF_FFFF_FFFF_FF80. LBU, same data → 0x80.
- SH at addr 0x8000_0006, rs2=0xABCD → `mem_addr`=0x8000_0000, `mem_wmask`=0xC0, `mem_wdata`=0xABCD_0000_0000_0000; `mem_req` held 3 cycles until a delayed gnt.
- LW at addr 0x8000_0002 → no `mem_req`; `MEM_misalign`=1 and `MEM_out`=0 in the next cycle.
- LD with no gnt, `TIMEOUT_CYCLES`=4 → after 4 REQ cycles: `mem_req` drops, `MEM_buserr`=1. Repeat with gnt arriving on the 4th cycle → no fault.
- Load result with `MEM_ready_in`=0 for 5 cycles → `MEM_out` stable and `MEM_ready_out`=0. Assert `rst` mid-WAIT → all outputs reset next cycle, and a late rvalid is ignored.
